// File: rtl/program_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : program_loader_pkg                                      |
// | Purpose : Loader FSM state encodings and state-decode helpers.    |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package program_loader_pkg;

  // Loader FSM encodings (4-bit)
  localparam logic [3:0] LDR_IDLE   = 4'd0;
  localparam logic [3:0] LDR_CNT_HI = 4'd1;
  localparam logic [3:0] LDR_CNT_LO = 4'd2;
  localparam logic [3:0] LDR_B2     = 4'd3;
  localparam logic [3:0] LDR_B1     = 4'd4;
  localparam logic [3:0] LDR_B0     = 4'd5;
  localparam logic [3:0] LDR_WRITE  = 4'd6;
  localparam logic [3:0] LDR_CHECK  = 4'd7;
  localparam logic [3:0] LDR_DONE   = 4'd8;
  localparam logic [3:0] LDR_ERROR  = 4'd9;

  // States in which a stream byte may be accepted
  function automatic logic is_rx_state(input logic [3:0] s);
    return (s == LDR_CNT_HI) || (s == LDR_CNT_LO) || (s == LDR_B2) ||
           (s == LDR_B1)     || (s == LDR_B0)     || (s == LDR_CHECK);
  endfunction

  // States in which a new load may be started
  function automatic logic is_rest_state(input logic [3:0] s);
    return (s == LDR_IDLE) || (s == LDR_DONE) || (s == LDR_ERROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : program_loader                                          |
// | Purpose : Receives a byte-stream program image, assembles 24-bit  |
// |           words, writes them to program RAM from address 0 and    |
// |           releases the CPU only after the checksum matches.       |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] prog_addr,
  output logic [23:0] prog_data,
  output logic        prog_write_en_n,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH);

  logic [3:0]  state;
  logic [3:0]  state_nxt;
  logic [15:0] count;
  logic [15:0] index;
  logic [7:0]  csum;
  logic [7:0]  lane2;
  logic [7:0]  lane1;
  logic        xfer;
  logic [15:0] count_full;
  logic        more_words;

  assign xfer       = in_valid & in_ready;
  // Full count as seen while count_lo is on the bus
  assign count_full = {count[15:8], in_data};
  // Compare in 17 bits so index+1 can never wrap
  assign more_words = ({1'b0, index} + 17'd1) < {1'b0, count};

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      LDR_IDLE, LDR_DONE, LDR_ERROR:
        if (start) state_nxt = LDR_CNT_HI;
      LDR_CNT_HI:
        if (xfer) state_nxt = LDR_CNT_LO;
      LDR_CNT_LO:
        if (xfer) begin
          if ({1'b0, count_full} > DEPTH_LIMIT) state_nxt = LDR_ERROR;
          else if (count_full == 16'd0)         state_nxt = LDR_CHECK;
          else                                  state_nxt = LDR_B2;
        end
      LDR_B2:
        if (xfer) state_nxt = LDR_B1;
      LDR_B1:
        if (xfer) state_nxt = LDR_B0;
      LDR_B0:
        if (xfer) state_nxt = LDR_WRITE;
      LDR_WRITE:
        state_nxt = more_words ? LDR_B2 : LDR_CHECK;
      LDR_CHECK:
        if (xfer) state_nxt = (in_data == csum) ? LDR_DONE : LDR_ERROR;
      default:
        state_nxt = LDR_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LDR_IDLE;
    else        state <= state_nxt;
  end

  // Datapath: count capture, byte lanes, word index, checksum, RAM port regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 16'd0;
      index     <= 16'd0;
      csum      <= 8'd0;
      lane2     <= 8'd0;
      lane1     <= 8'd0;
      prog_addr <= 16'd0;
      prog_data <= 24'd0;
    end else begin
      // A fresh load restarts the index and checksum
      if (start && is_rest_state(state)) begin
        index <= 16'd0;
        csum  <= 8'd0;
      end
      // The checksum byte itself is not part of the sum
      if (xfer && (state != LDR_CHECK)) csum <= csum + in_data;
      if (xfer) begin
        case (state)
          LDR_CNT_HI: count[15:8] <= in_data;
          LDR_CNT_LO: count[7:0]  <= in_data;
          LDR_B2:     lane2       <= in_data;
          LDR_B1:     lane1       <= in_data;
          LDR_B0: begin
            // Address and data settle before the WRITE cycle and then hold
            prog_data <= {lane2, lane1, in_data};
            prog_addr <= index;
          end
          default: ;
        endcase
      end
      if (state == LDR_WRITE) index <= index + 16'd1;
    end
  end

  // Outputs decoded purely from state
  assign in_ready        = is_rx_state(state);
  assign prog_write_en_n = (state != LDR_WRITE);
  assign cpu_hold        = (state != LDR_DONE);
  assign busy            = !is_rest_state(state);
  assign done            = (state == LDR_DONE);
  assign error           = (state == LDR_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_program_loader                                       |
// | Purpose : Directed, table-driven self-checking bench for the      |
// |           program loader.                                         |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] prog_addr;
  logic [23:0] prog_data;
  logic        prog_write_en_n;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  program_loader #(.DEPTH(256)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .prog_addr       (prog_addr),
    .prog_data       (prog_data),
    .prog_write_en_n (prog_write_en_n),
    .cpu_hold        (cpu_hold),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Write monitor: every strobe cycle is one recorded word
  logic [15:0] wr_addr [0:7];
  logic [23:0] wr_data [0:7];
  int          wr_n = 0;
  int          rdy_in_write = 0;

  always @(negedge clk) begin
    if (!prog_write_en_n) begin
      if (wr_n < 8) begin
        wr_addr[wr_n] = prog_addr;
        wr_data[wr_n] = prog_data;
      end
      wr_n++;
      if (in_ready) rdy_in_write++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Image stored left-aligned; byte i is bits [127-8i -: 8]
  typedef struct packed {
    logic [127:0] img;
    int           len;
    bit           rnd;
    int           exp_n;
    logic [95:0]  words;   // word k at [95-24k -: 24]
    bit           exp_done;
    bit           exp_err;
  } vec_t;

  // Drive bytes at negedge; a byte counts if valid&ready before the next posedge
  task automatic send(input logic [127:0] img, input int nbytes, input bit rnd,
                      output int cyc);
    int  i;
    bit  x;
    i   = 0;
    cyc = 0;
    while (i < nbytes && cyc < 400) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = img[127-8*i -: 8];
      #1;
      x = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (x) i++;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk("byte_timeout", i, nbytes);
  endtask

  task automatic pulse_start();
    wr_n         = 0;
    rdy_in_write = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_prog_addr"}, prog_addr, 0);
    chk({tag, "_prog_data"}, prog_data, 0);
    chk({tag, "_we_n"}, prog_write_en_n, 1);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  vec_t vecs [0:5];

  initial begin
    int cyc;

    vecs[0] = '{img: {72'h0002123456ABCDEF05, 56'h0}, len: 9, rnd: 0, exp_n: 2,
                words: {24'h123456, 24'hABCDEF, 48'h0}, exp_done: 1, exp_err: 0};
    vecs[1] = '{img: {72'h0002123456ABCDEF06, 56'h0}, len: 9, rnd: 0, exp_n: 2,
                words: {24'h123456, 24'hABCDEF, 48'h0}, exp_done: 0, exp_err: 1};
    vecs[2] = '{img: {24'h000000, 104'h0}, len: 3, rnd: 0, exp_n: 0,
                words: 96'h0, exp_done: 1, exp_err: 0};
    vecs[3] = '{img: {16'h0101, 112'h0}, len: 2, rnd: 0, exp_n: 0,
                words: 96'h0, exp_done: 0, exp_err: 1};
    vecs[4] = '{img: {72'h0002123456ABCDEF05, 56'h0}, len: 9, rnd: 1, exp_n: 2,
                words: {24'h123456, 24'hABCDEF, 48'h0}, exp_done: 1, exp_err: 0};
    vecs[5] = '{img: {48'h000101020307, 80'h0}, len: 6, rnd: 0, exp_n: 1,
                words: {24'h010203, 72'h0}, exp_done: 1, exp_err: 0};

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    // Table-driven loads
    for (int v = 0; v < 6; v++) begin
      pulse_start();
      chk($sformatf("v%0d_busy_start", v), busy, 1);
      send(vecs[v].img, vecs[v].len, vecs[v].rnd, cyc);
      chk($sformatf("v%0d_done", v), done, vecs[v].exp_done);
      chk($sformatf("v%0d_error", v), error, vecs[v].exp_err);
      chk($sformatf("v%0d_cpu_hold", v), cpu_hold, !vecs[v].exp_done);
      chk($sformatf("v%0d_busy_end", v), busy, 0);
      chk($sformatf("v%0d_in_ready_end", v), in_ready, 0);
      chk($sformatf("v%0d_write_count", v), wr_n, vecs[v].exp_n);
      chk($sformatf("v%0d_ready_in_write", v), rdy_in_write, 0);
      if (!vecs[v].rnd)
        chk($sformatf("v%0d_cycles", v), cyc, vecs[v].len + vecs[v].exp_n);
      for (int k = 0; k < vecs[v].exp_n && k < wr_n; k++) begin
        chk($sformatf("v%0d_addr%0d", v, k), wr_addr[k], k);
        chk($sformatf("v%0d_data%0d", v, k), wr_data[k], vecs[v].words[95-24*k -: 24]);
      end
      // A failed image must keep the CPU halted over further cycles
      @(negedge clk);
      chk($sformatf("v%0d_done_hold", v), done, vecs[v].exp_done);
      chk($sformatf("v%0d_hold_hold", v), cpu_hold, !vecs[v].exp_done);
    end

    // Start while busy is ignored: load must still finish normally
    pulse_start();
    send(vecs[0].img, 3, 1'b0, cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send({vecs[0].img[127-24:0], 24'h0}, 6, 1'b0, cyc);
    chk("busy_start_done", done, 1);
    chk("busy_start_writes", wr_n, 2);

    // Asynchronous reset while in B1 of word 1
    pulse_start();
    send(vecs[0].img, 6, 1'b0, cyc);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_in_ready", in_ready, 1);
    chk("pre_rst_prog_data", prog_data, 24'h123456);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    send(vecs[0].img, 9, 1'b0, cyc);
    chk("reload_done", done, 1);
    chk("reload_cpu_hold", cpu_hold, 0);
    chk("reload_writes", wr_n, 2);
    chk("reload_addr0", wr_addr[0], 0);
    chk("reload_data0", wr_data[0], 24'h123456);
    chk("reload_addr1", wr_addr[1], 1);
    chk("reload_data1", wr_data[1], 24'hABCDEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
